// File: rtl/soc_status_pkg.sv
// Shared definitions for the SoC status/supervision peripheral.
// Firmware headers use the same register offsets and bit positions.
package soc_status_pkg;

  // Register word offsets.
  localparam logic [2:0] REG_HALT    = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_WDOG    = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;

  // Bit positions shared by STATUS (read) and CTRL (write-1-to-clear).
  localparam int BIT_HALTED   = 0;
  localparam int BIT_DSP_DONE = 1;
  localparam int BIT_WDOG     = 2;

  // Program-completion signature written to HALT by firmware.
  localparam logic [31:0] HALT_SIG_DEFAULT = 32'hDEADBEEF;

  // Assemble the STATUS word; unused bits read as 0.
  function automatic logic [31:0] pack_status(input logic halted,
                                              input logic dsp_done,
                                              input logic wdog_expired);
    logic [31:0] word;
    word               = '0;
    word[BIT_HALTED]   = halted;
    word[BIT_DSP_DONE] = dsp_done;
    word[BIT_WDOG]     = wdog_expired;
    return word;
  endfunction

endpackage

// File: rtl/status_wdog_timer.sv
// Software watchdog down-counter.
// A load writes a new count; a nonzero count decrements once per cycle and
// a zero count is idle (disabled). expire_o is high in the cycle whose
// closing edge takes the count from 1 to 0, unless a load lands on that edge.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   load_i         : load load_val_i on this edge (wins over the decrement)
//   load_val_i     : new count
//   count_o        : live count
//   expire_o       : expiry pulse, aligned with the 1 -> 0 edge
module status_wdog_timer #(
  parameter int WDOG_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WDOG_W-1:0] load_val_i,
  output logic [WDOG_W-1:0] count_o,
  output logic              expire_o
);

  localparam logic [WDOG_W-1:0] ONE = WDOG_W'(1);

  logic [WDOG_W-1:0] count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  // A load on the final step restarts the countdown instead of expiring.
  assign expire_o = !load_i && (count_q == ONE);
  assign count_o  = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/soc_status_ctrl.sv
// Memory-mapped status and supervision slave.
// Latches the program-completion signature, DSP completion and watchdog
// expiry into sticky flags, and drives the board status LEDs.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   bus_sel_i/we_i      : transfer select and direction (1 = write)
//   bus_addr_i          : word offset within the block
//   bus_wdata_i         : write data
//   bus_rdata_o         : read data, 0 unless bus_rvalid_o
//   bus_rvalid_o        : one-cycle pulse, the cycle after a read request
//   dsp_done_i          : DSP done level
//   cpu_halted_led_o    : halted flag (cleared only by reset)
//   dsp_done_led_o      : sticky DSP-done flag
//   wdog_expired_o      : sticky watchdog-expired flag
//   heartbeat_led_o     : toggles every 2^HB_DIV cycles
module soc_status_ctrl
  import soc_status_pkg::*;
#(
  parameter logic [31:0] HALT_SIG = HALT_SIG_DEFAULT,
  parameter int          HB_DIV   = 24,
  parameter int          WDOG_W   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_sel_i,
  input  logic        bus_we_i,
  input  logic [2:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_rvalid_o,
  input  logic        dsp_done_i,
  output logic        cpu_halted_led_o,
  output logic        dsp_done_led_o,
  output logic        wdog_expired_o,
  output logic        heartbeat_led_o
);

  localparam logic [HB_DIV-1:0] HB_ONE = HB_DIV'(1);

  logic [31:0]       halt_q, halt_d;
  logic [31:0]       scratch_q, scratch_d;
  logic              halted_q, halted_d;
  logic              dsp_sync_q;
  logic              dsp_done_q, dsp_done_d;
  logic              wdog_exp_q, wdog_exp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [HB_DIV-1:0] hb_cnt_q, hb_cnt_d;
  logic              hb_led_q, hb_led_d;

  logic              wr, rd;
  logic              wr_ctrl, wr_wdog;
  logic              dsp_rise;
  logic [WDOG_W-1:0] wdog_count;
  logic              wdog_expire;

  assign wr      = bus_sel_i &&  bus_we_i;
  assign rd      = bus_sel_i && !bus_we_i;
  assign wr_ctrl = wr && (bus_addr_i == REG_CTRL);
  assign wr_wdog = wr && (bus_addr_i == REG_WDOG);

  // Only a 0 -> 1 change sets the flag, so a level still high after a
  // software clear does not re-arm it.
  assign dsp_rise = dsp_done_i && !dsp_sync_q;

  status_wdog_timer #(
    .WDOG_W(WDOG_W)
  ) u_wdog (
    .clock      (clock),
    .reset      (reset),
    .load_i     (wr_wdog),
    .load_val_i (bus_wdata_i[WDOG_W-1:0]),
    .count_o    (wdog_count),
    .expire_o   (wdog_expire)
  );

  always_comb begin
    halt_d    = halt_q;
    scratch_d = scratch_q;
    halted_d  = halted_q;
    rvalid_d  = rd;
    rdata_d   = '0;

    if (wr && (bus_addr_i == REG_HALT)) begin
      halt_d = bus_wdata_i;
      if (bus_wdata_i == HALT_SIG) begin
        halted_d = 1'b1;
      end
    end
    if (wr && (bus_addr_i == REG_SCRATCH)) begin
      scratch_d = bus_wdata_i;
    end

    // A set on the same edge as a W1C clear wins.
    dsp_done_d = dsp_rise ||
                 (dsp_done_q && !(wr_ctrl && bus_wdata_i[BIT_DSP_DONE]));
    wdog_exp_d = wdog_expire ||
                 (wdog_exp_q && !(wr_ctrl && bus_wdata_i[BIT_WDOG]));

    if (rd) begin
      case (bus_addr_i)
        REG_HALT:    rdata_d = halt_q;
        REG_SCRATCH: rdata_d = scratch_q;
        REG_STATUS:  rdata_d = pack_status(halted_q, dsp_done_q, wdog_exp_q);
        REG_WDOG:    rdata_d = 32'(wdog_count);
        default:     rdata_d = '0;
      endcase
    end

    hb_cnt_d = hb_cnt_q + HB_ONE;
    hb_led_d = hb_led_q ^ (&hb_cnt_q);
  end

  // NOTE: reset is synchronous and clears every register, including the
  // read-data pipeline, so a read in flight when reset hits is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      halt_q     <= '0;
      scratch_q  <= '0;
      halted_q   <= 1'b0;
      dsp_sync_q <= 1'b0;
      dsp_done_q <= 1'b0;
      wdog_exp_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      hb_cnt_q   <= '0;
      hb_led_q   <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      scratch_q  <= scratch_d;
      halted_q   <= halted_d;
      dsp_sync_q <= dsp_done_i;
      dsp_done_q <= dsp_done_d;
      wdog_exp_q <= wdog_exp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_led_q   <= hb_led_d;
    end
  end

  assign bus_rdata_o      = rdata_q;
  assign bus_rvalid_o     = rvalid_q;
  assign cpu_halted_led_o = halted_q;
  assign dsp_done_led_o   = dsp_done_q;
  assign wdog_expired_o   = wdog_exp_q;
  assign heartbeat_led_o  = hb_led_q;

endmodule

// File: tb/tb_soc_status_ctrl.sv
// Self-checking bench for soc_status_ctrl. Reads push their hand-computed
// expected data into a queue; an independent monitor on the falling edge
// pops and compares whenever the DUT presents bus_rvalid_o.
module tb_soc_status_ctrl;
  import soc_status_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        dsp_done = 1'b0;
  logic        halted_led, dsp_led, wdog_exp, hb_led;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  soc_status_ctrl #(
    .HALT_SIG(32'hDEADBEEF),
    .HB_DIV  (3),
    .WDOG_W  (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_sel_i        (bus_sel),
    .bus_we_i         (bus_we),
    .bus_addr_i       (bus_addr),
    .bus_wdata_i      (bus_wdata),
    .bus_rdata_o      (bus_rdata),
    .bus_rvalid_o     (bus_rvalid),
    .dsp_done_i       (dsp_done),
    .cpu_halted_led_o (halted_led),
    .dsp_done_led_o   (dsp_led),
    .wdog_expired_o   (wdog_exp),
    .heartbeat_led_o  (hb_led)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs checked there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    tick();
    bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] expected);
    exp_q.push_back(expected);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = addr;
    tick();
    bus_sel = 1'b0;
    check($sformatf("rvalid_latency@%0d", addr), {31'b0, bus_rvalid}, 32'd1);
  endtask

  task automatic check_flags(input string tag, input logic h, input logic d,
                             input logic w);
    check({tag, "_halted"}, {31'b0, halted_led}, {31'b0, h});
    check({tag, "_dsp"},    {31'b0, dsp_led},    {31'b0, d});
    check({tag, "_wdog"},   {31'b0, wdog_exp},   {31'b0, w});
  endtask

  // Monitor: compares read data whenever the DUT presents it.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus_rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {31'b0, bus_rvalid}, 32'd0);
        end else begin
          check("rdata", bus_rdata, exp_q.pop_front());
        end
      end else begin
        check("rdata_idle_zero", bus_rdata, 32'd0);
      end
    end
  end

  initial begin
    int n;

    // Reset and idle.
    repeat (3) tick();
    reset = 1'b0;
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset_hb", {31'b0, hb_led}, 32'd0);
    check("reset_rvalid", {31'b0, bus_rvalid}, 32'd0);
    repeat (10) tick();
    check_flags("idle", 1'b0, 1'b0, 1'b0);
    bus_read(REG_STATUS, 32'h0);

    // HALT signature.
    bus_write(REG_HALT, 32'h12345678);
    check("halt_non_sig", {31'b0, halted_led}, 32'd0);
    bus_read(REG_HALT, 32'h12345678);
    bus_write(REG_HALT, 32'hDEADBEEF);
    check("halt_sig", {31'b0, halted_led}, 32'd1);
    bus_write(REG_HALT, 32'h0);
    check("halt_sticky", {31'b0, halted_led}, 32'd1);
    bus_read(REG_STATUS, 32'h1);

    // DSP done edge detect and W1C.
    dsp_done = 1'b1;
    tick();
    check("dsp_rise", {31'b0, dsp_led}, 32'd1);
    repeat (19) tick();
    bus_write(REG_CTRL, 32'h2);
    check("dsp_clear", {31'b0, dsp_led}, 32'd0);
    repeat (5) tick();
    check("dsp_level_no_reset", {31'b0, dsp_led}, 32'd0);
    bus_read(REG_STATUS, 32'h1);
    dsp_done = 1'b0;
    tick();
    dsp_done = 1'b1;
    tick();
    check("dsp_second_rise", {31'b0, dsp_led}, 32'd1);
    bus_read(REG_STATUS, 32'h3);
    bus_write(REG_CTRL, 32'h2);
    dsp_done = 1'b0;
    check("dsp_clear2", {31'b0, dsp_led}, 32'd0);

    // Watchdog: write 5 at edge t, expiry visible after edge t+5.
    bus_write(REG_WDOG, 32'd5);              // edge t
    bus_read(REG_WDOG, 32'd5);               // edge t+1 samples count 5
    repeat (3) tick();                       // edge t+4
    check("wdog_before", {31'b0, wdog_exp}, 32'd0);
    tick();                                  // edge t+5
    check("wdog_expire", {31'b0, wdog_exp}, 32'd1);
    bus_write(REG_CTRL, 32'h4);
    check("wdog_clear", {31'b0, wdog_exp}, 32'd0);

    // Reload on the final step: no expiry, then expiry 3 cycles later.
    bus_write(REG_WDOG, 32'd3);              // edge t, count 3
    repeat (2) tick();                       // count 1
    bus_write(REG_WDOG, 32'd3);              // reload on the 1 -> 0 edge
    check("wdog_reload_wins", {31'b0, wdog_exp}, 32'd0);
    repeat (2) tick();
    check("wdog_reload_before", {31'b0, wdog_exp}, 32'd0);
    tick();
    check("wdog_reload_expire", {31'b0, wdog_exp}, 32'd1);

    // Clear coinciding with expiry: set wins.
    bus_write(REG_CTRL, 32'h4);
    check("wdog_clear3", {31'b0, wdog_exp}, 32'd0);
    bus_write(REG_WDOG, 32'd2);              // count 2
    tick();                                  // count 1
    bus_write(REG_CTRL, 32'h4);              // same edge as 1 -> 0
    check("wdog_set_wins", {31'b0, wdog_exp}, 32'd1);

    // Register map odds and ends.
    bus_write(REG_SCRATCH, 32'hA5A55A5A);
    bus_read(REG_SCRATCH, 32'hA5A55A5A);
    bus_write(3'd6, 32'hFFFFFFFF);
    bus_read(3'd5, 32'h0);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h0);
    bus_read(REG_CTRL, 32'h0);
    bus_read(REG_STATUS, 32'h5);
    bus_read(REG_WDOG, 32'h0);

    // Reset mid-countdown with a read request on the reset edge.
    bus_write(REG_WDOG, 32'd100);
    repeat (5) tick();
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = REG_STATUS; reset = 1'b1;
    tick();
    bus_sel = 1'b0; reset = 1'b0;
    check_flags("rst2", 1'b0, 1'b0, 1'b0);
    check("rst2_rvalid_dropped", {31'b0, bus_rvalid}, 32'd0);
    check("rst2_hb", {31'b0, hb_led}, 32'd0);

    // Heartbeat period with HB_DIV=3: 8 edges per toggle.
    n = 0;
    while (hb_led == 1'b0 && n < 40) begin tick(); n++; end
    check("hb_rise_period", n, 32'd8);
    n = 0;
    while (hb_led == 1'b1 && n < 40) begin tick(); n++; end
    check("hb_fall_period", n, 32'd8);

    bus_read(REG_WDOG, 32'h0);
    repeat (110) tick();
    check("wdog_never_expires", {31'b0, wdog_exp}, 32'd0);

    // Drain outstanding reads with a bounded wait.
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin tick(); n++; end
    check("reads_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_status_ctrl.md
# soc_status_ctrl

Memory-mapped status and supervision peripheral that sits directly downstream of the processor's bus interconnect, as one more slave beside data memory and the DSP. It latches the program-completion signature, DSP completion and a software watchdog into sticky flags and drives the board status LEDs from registers. This replaces any hierarchical probing of data memory. It is the only source of `cpu_halted_led_o` and `dsp_done_led_o` at SoC top.

## Interface
Parameters:
- `HALT_SIG`, 32'hDEADBEEF, value whose write to HALT sets the halted flag
- `HB_DIV`, 24, heartbeat LED toggles every 2^HB_DIV cycles (legal 1..31)
- `WDOG_W`, 32, watchdog counter width

Ports:
- `clock` in 1: single clock for all state
- `reset` in 1: synchronous, active-high; all state is cleared on the clock edge where it is high
- `bus_sel_i` in 1: slave select from the interconnect; a transfer occurs in any cycle with `bus_sel_i`=1
- `bus_we_i` in 1: 1 = write, 0 = read
- `bus_addr_i` in 3: word offset within the block
- `bus_wdata_i` in 32: write data
- `bus_rdata_o` out 32: read data
- `bus_rvalid_o` out 1: read data valid, one-cycle pulse
- `dsp_done_i` in 1: DSP done level
- `cpu_halted_led_o` out 1: halted flag
- `dsp_done_led_o` out 1: sticky DSP-done flag
- `wdog_expired_o` out 1: sticky watchdog-expired flag
- `heartbeat_led_o` out 1: free-running blink

## Operation
Register map (word offsets):
- 0 HALT, R/W. A write stores `bus_wdata_i`. If the value equals `HALT_SIG`, `halted` is set. `halted` is never cleared except by reset.
- 1 SCRATCH, R/W, 32-bit.
- 2 STATUS, RO. bit0 = halted, bit1 = dsp_done, bit2 = wdog_expired, other bits 0.
- 3 WDOG, R/W. A write loads the counter (low `WDOG_W` bits). A read returns the live count.
- 4 CTRL, W1C. Writing 1 to bit1 clears dsp_done; writing 1 to bit2 clears wdog_expired. Reads return 0.
- 5–7: reads return 0; writes are ignored.

DSP done:
- `dsp_done_i` is registered once.
- A rising edge (registered value 0 → current 1) sets `dsp_done`.
- A level held high does not re-set the flag after a clear.

Watchdog:
- The counter decrements by 1 each cycle while it is nonzero.
- A transition from 1 to 0 sets `wdog_expired`.
- A count of 0 means disabled: the counter stays at 0.

Heartbeat:
- A free-running `HB_DIV`-bit counter drives the LED.
- `heartbeat_led_o` toggles each time the counter wraps to 0.

Simultaneous events:
- A WDOG write in the same cycle as the 1 → 0 step: the write wins and expiry is not flagged.
- A CTRL clear in the same cycle as a set of the same flag: the set wins.
- A read and a write to the same register cannot occur in one cycle (single `bus_we_i`).

Reset: at any point, including mid-countdown or mid-read, all registers, counters and outputs return to 0 on the next edge. A pending `bus_rvalid_o` is dropped.

## Timing
- Writes: take effect on the edge where sel=1 and we=1. The flag outputs are registered, so a flag changes one cycle after the write edge.
- Reads: `bus_rvalid_o`=1 and `bus_rdata_o` valid in the cycle after the sel=1, we=0 cycle. Latency is 1, with a new read accepted every cycle.
- `bus_rdata_o` is 0 whenever `bus_rvalid_o`=0.
- DSP done: `dsp_done_led_o` rises 1 cycle after the first cycle in which `dsp_done_i` is high.
- Watchdog: a write of N at edge t gives expiry visible on `wdog_expired_o` after edge t+N.
- Reset values: every output is 0.

## Structure
- Shared package `soc_status_pkg` holds:
  - register offset constants: HALT=0, SCRATCH=1, STATUS=2, WDOG=3, CTRL=4
  - STATUS/CTRL bit positions: HALTED=0, DSP_DONE=1, WDOG=2
  - default `HALT_SIG`
- Firmware headers use the same offsets.
- Natural sub-module: `status_wdog_timer` (load, decrement, expiry pulse).
- Register file, edge detect and heartbeat stay in the top module.

## Test plan
- Reset, then idle 10 cycles → all outputs 0; STATUS read returns 0, with `bus_rvalid_o` 1 cycle after the request.
- Write HALT=0x12345678 → `cpu_halted_led_o` stays 0 and a HALT read returns 0x12345678. Then write HALT=0xDEADBEEF → LED 1 one cycle later; write HALT=0 → LED stays 1.
- Hold `dsp_done_i` high 20 cycles → `dsp_done_led_o`=1. CTRL write 0x2 while still high → flag 0 and stays 0. Drop the input, raise it again → flag 1.
- Write WDOG=5 at edge t → `wdog_expired_o`=1 after edge t+5. WDOG write of 3 on the cycle the count is 1 → no expiry; expiry 3 cycles later.
- CTRL 0x4 in the same cycle as watchdog expiry → flag is 1. Reads of offsets 5–7 return 0.
- With `HB_DIV`=3: `heartbeat_led_o` toggles every 8 cycles. Assert reset mid-countdown (count=100) → WDOG reads 0 and the watchdog never expires.
